// File: rtl/la_wb_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the Wishbone
// slave port and an LA-driven command channel with a 4-phase handshake.
module la_wb_arbiter #(
  parameter int unsigned AW        = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          la_req_i,
  input  logic          la_we_i,
  input  logic [AW-1:0] la_addr_i,
  input  logic [31:0]   la_wdata_i,
  output logic [31:0]   la_rdata_o,
  output logic          la_done_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_wmask_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {GNT_WB, GNT_LA} grant_t;

  state_t       state_q, state_d;
  grant_t       gnt_q, last_q;
  logic         op_we_q;
  logic [2:0]   wait_cnt_q;
  logic [31:0]  rdata_q;
  logic         la_req_q;
  logic         la_pend_q;
  logic         wb_req;
  logic         grant_wb, grant_la;
  logic         wait_last;

  assign wb_req    = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign wait_last = (wait_cnt_q == 3'(MEM_LAT - 1));

  // Outputs decoded from the current state; ack requires the WB request to still be live.
  assign busy_o    = (state_q != IDLE);
  assign mem_en_o  = (state_q == ISSUE);
  assign mem_we_o  = (state_q == ISSUE) && op_we_q;
  assign wbs_ack_o = (state_q == RESP) && (gnt_q == GNT_WB) && wb_req;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next-state decode; on a tie the requester not served last wins.
  always_comb begin
    state_d  = state_q;
    grant_wb = 1'b0;
    grant_la = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_req && la_pend_q) begin
          if (last_q == GNT_LA) grant_wb = 1'b1;
          else                  grant_la = 1'b1;
        end else if (wb_req) begin
          grant_wb = 1'b1;
        end else if (la_pend_q) begin
          grant_la = 1'b1;
        end
        if (grant_wb || grant_la) state_d = ISSUE;
      end
      ISSUE: state_d = op_we_q ? RESP : WAIT;
      WAIT:  if (wait_last) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LA request edge detect and pending flag; a grant clears the flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      la_req_q  <= 1'b0;
      la_pend_q <= 1'b0;
    end else begin
      la_req_q <= la_req_i;
      if (grant_la) begin
        la_pend_q <= 1'b0;
      end else if (la_req_i && !la_req_q) begin
        la_pend_q <= 1'b1;
      end
    end
  end

  // Latch the granted operation; memory-side fields hold until the next grant.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gnt_q       <= GNT_WB;
      last_q      <= GNT_LA;
      op_we_q     <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
    end else if (grant_wb) begin
      gnt_q       <= GNT_WB;
      last_q      <= GNT_WB;
      op_we_q     <= wbs_we_i;
      mem_addr_o  <= wbs_adr_i[AW+1:2];
      mem_wdata_o <= wbs_dat_i;
      mem_wmask_o <= wbs_sel_i;
    end else if (grant_la) begin
      gnt_q       <= GNT_LA;
      last_q      <= GNT_LA;
      op_we_q     <= la_we_i;
      mem_addr_o  <= la_addr_i;
      mem_wdata_o <= la_wdata_i;
      mem_wmask_o <= '1;
    end
  end

  // Read latency counter and data capture in the cycle the memory output is valid.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      wbs_dat_o  <= '0;
    end else begin
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 3'd1;
      end
      // WB data is registered here so it is already valid while ack is high in RESP.
      if ((state_q == WAIT) && wait_last) begin
        rdata_q <= mem_rdata_i;
        if (gnt_q == GNT_WB) wbs_dat_o <= mem_rdata_i;
      end
    end
  end

  // LA completion: set from RESP, cleared once firmware lowers the request.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      la_done_o  <= 1'b0;
      la_rdata_o <= '0;
    end else if ((state_q == RESP) && (gnt_q == GNT_LA)) begin
      la_done_o <= 1'b1;
      if (!op_we_q) la_rdata_o <= rdata_q;
    end else if (!la_req_i) begin
      la_done_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_la_wb_arbiter.sv
// Directed bench for la_wb_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance.
module tb_la_wb_arbiter;

  localparam int AW = 8;

  typedef struct packed {
    logic          we;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance signals
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = '0;
  logic [31:0]   adr = '0, dat_i = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic          la_req = 1'b0, la_we = 1'b0;
  logic [AW-1:0] la_addr = '0;
  logic [31:0]   la_wdata = '0;
  logic [31:0]   la_rdata;
  logic          la_done;
  logic          mem_en, mem_we;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          busy;

  // MEM_LAT=3 instance signals
  logic          c3_cyc = 1'b0, c3_stb = 1'b0, c3_we = 1'b0;
  logic [3:0]    c3_sel = '0;
  logic [31:0]   c3_adr = '0, c3_dat_i = '0;
  logic          ack3;
  logic [31:0]   dat3;
  logic          l3_req = 1'b0, l3_we = 1'b0;
  logic [AW-1:0] l3_addr = '0;
  logic [31:0]   l3_wdata = '0;
  logic [31:0]   l3_rdata;
  logic          l3_done;
  logic          m3_en, m3_we;
  logic [3:0]    m3_wmask;
  logic [AW-1:0] m3_addr;
  logic [31:0]   m3_wdata, m3_rdata;
  logic          busy3;

  la_wb_arbiter #(.AW(AW), .BASE_ADDR(32'h3000_0000), .ADDR_MASK(32'hFFFF_FC00), .MEM_LAT(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .la_req_i(la_req), .la_we_i(la_we), .la_addr_i(la_addr), .la_wdata_i(la_wdata),
    .la_rdata_o(la_rdata), .la_done_o(la_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_wmask_o(mem_wmask),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  la_wb_arbiter #(.AW(AW), .BASE_ADDR(32'h3000_0000), .ADDR_MASK(32'hFFFF_FC00), .MEM_LAT(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(c3_cyc), .wbs_stb_i(c3_stb), .wbs_we_i(c3_we), .wbs_sel_i(c3_sel),
    .wbs_adr_i(c3_adr), .wbs_dat_i(c3_dat_i), .wbs_ack_o(ack3), .wbs_dat_o(dat3),
    .la_req_i(l3_req), .la_we_i(l3_we), .la_addr_i(l3_addr), .la_wdata_i(l3_wdata),
    .la_rdata_o(l3_rdata), .la_done_o(l3_done),
    .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_wmask_o(m3_wmask),
    .mem_addr_o(m3_addr), .mem_wdata_o(m3_wdata), .mem_rdata_i(m3_rdata),
    .busy_o(busy3)
  );

  // Memory models: read data is valid only in the exact cycle, garbage otherwise.
  logic [31:0] mem1 [0:255];
  logic [31:0] p1;
  logic        v1 = 1'b0;
  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem1[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    v1 <= mem_en && !mem_we;
    p1 <= mem1[mem_addr];
  end
  assign mem_rdata = v1 ? p1 : 32'hBAD0_BAD0;

  logic [31:0] mem3 [0:255];
  logic [31:0] p3 [0:2];
  logic [2:0]  v3 = '0;
  always @(posedge clk) begin
    if (m3_en && m3_we)
      for (int b = 0; b < 4; b++)
        if (m3_wmask[b]) mem3[m3_addr][b*8 +: 8] <= m3_wdata[b*8 +: 8];
    v3    <= {v3[1:0], m3_en && !m3_we};
    p3[0] <= mem3[m3_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m3_rdata = v3[2] ? p3[2] : 32'hBAD0_BAD0;

  // Log of every memory access of the MEM_LAT=1 instance.
  acc_t log_q[$];
  always @(negedge clk) begin
    if (mem_en) log_q.push_back('{we: mem_we, mask: mem_wmask, addr: mem_addr, wdata: mem_wdata});
  end

  int checks = 0;
  int fails  = 0;

  int          wb_lat, la_lat, ack_cnt, clr_lat;
  logic [31:0] wb_rd, la_rd;
  bit          wb_act = 1'b0, la_act = 1'b0, timed_out = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic acc_t log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return '0;
  endfunction

  task automatic wb_start(input logic we_v, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = we_v; sel = 4'hF; adr = a; dat_i = d;
    wb_act = 1'b1;
  endtask

  task automatic la_start(input logic we_v, input logic [AW-1:0] a, input logic [31:0] d);
    la_we = we_v; la_addr = a; la_wdata = d; la_req = 1'b1;
    la_act = 1'b1;
  endtask

  // Services whichever requesters are active until both handshakes finish.
  task automatic run(input int maxc);
    int  n = 0;
    bit  drop_wb = 1'b0;
    int  la_drop_at = -1;
    bit  done = 1'b0;
    wb_lat = -1; la_lat = -1; ack_cnt = 0; clr_lat = -1; timed_out = 1'b0;
    while (n < maxc && !done) begin
      @(negedge clk);
      n++;
      if (ack) begin
        ack_cnt++;
        if (wb_lat < 0) begin wb_lat = n; wb_rd = dat_o; end
      end
      if (la_done && la_lat < 0) begin la_lat = n; la_rd = la_rdata; end
      if (la_drop_at >= 0 && !la_done && clr_lat < 0) clr_lat = n - la_drop_at;
      if (drop_wb) begin
        cyc = 1'b0; stb = 1'b0; wb_act = 1'b0; drop_wb = 1'b0;
      end else if (wb_act && ack) begin
        drop_wb = 1'b1;
      end
      if (la_act && la_done) begin
        la_req = 1'b0; la_act = 1'b0; la_drop_at = n;
      end
      if (!wb_act && !drop_wb && !la_act && !la_done && !busy) done = 1'b1;
    end
    if (!done) begin
      timed_out = 1'b1;
      cyc = 1'b0; stb = 1'b0; la_req = 1'b0; wb_act = 1'b0; la_act = 1'b0;
    end
    chk("run_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic wb3_txn(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd);
    int n = 0;
    lat = -1; rd = '0;
    c3_cyc = 1'b1; c3_stb = 1'b1; c3_we = we_v; c3_sel = 4'hF; c3_adr = a; c3_dat_i = d;
    while (n < 30 && lat < 0) begin
      @(negedge clk);
      n++;
      if (ack3) begin lat = n; rd = dat3; end
    end
    @(negedge clk);
    c3_cyc = 1'b0; c3_stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          base;
    int          cnt_ack, cnt_en, cnt_busy;
    int          lat3;
    logic [31:0] rd3;
    acc_t        e;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_la_done", 32'(la_done), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_dat", dat_o, 32'd0);
    chk("rst_la_rdata", la_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WB write 0xDEADBEEF to 0x3000_0010
    base = log_q.size();
    wb_start(1'b1, 32'h3000_0010, 32'hDEAD_BEEF);
    run(30);
    e = log_at(base);
    chk("wbw_lat", 32'(wb_lat), 32'd2);
    chk("wbw_ack_cnt", 32'(ack_cnt), 32'd1);
    chk("wbw_accesses", 32'(log_q.size() - base), 32'd1);
    chk("wbw_we", 32'(e.we), 32'd1);
    chk("wbw_addr", 32'(e.addr), 32'd4);
    chk("wbw_mask", 32'(e.mask), 32'hF);
    chk("wbw_wdata", e.wdata, 32'hDEAD_BEEF);

    // WB readback
    base = log_q.size();
    wb_start(1'b0, 32'h3000_0010, 32'h0);
    run(30);
    e = log_at(base);
    chk("wbr_lat", 32'(wb_lat), 32'd3);
    chk("wbr_data", wb_rd, 32'hDEAD_BEEF);
    chk("wbr_we", 32'(e.we), 32'd0);
    chk("wbr_addr", 32'(e.addr), 32'd4);

    // LA write addr 5
    base = log_q.size();
    la_start(1'b1, 8'd5, 32'h1234_5678);
    run(30);
    e = log_at(base);
    chk("law_done_lat", 32'(la_lat), 32'd4);
    chk("law_clr_lat", 32'(clr_lat), 32'd1);
    chk("law_addr", 32'(e.addr), 32'd5);
    chk("law_mask", 32'(e.mask), 32'hF);
    chk("law_wdata", e.wdata, 32'h1234_5678);

    // LA read addr 5
    la_start(1'b0, 8'd5, 32'h0);
    run(30);
    chk("lar_done_lat", 32'(la_lat), 32'd5);
    chk("lar_data", la_rd, 32'h1234_5678);
    chk("lar_clr_lat", 32'(clr_lat), 32'd1);

    // Tie with last grant LA: WB served first, LA right after
    base = log_q.size();
    la_start(1'b1, 8'd9, 32'hA5A5_0009);
    @(negedge clk);
    wb_start(1'b1, 32'h3000_0020, 32'h0BAD_CAFE);
    run(40);
    chk("tie1_first_addr", 32'(log_at(base).addr), 32'd8);
    chk("tie1_second_addr", 32'(log_at(base + 1).addr), 32'd9);
    chk("tie1_wb_lat", 32'(wb_lat), 32'd2);
    chk("tie1_la_lat", 32'(la_lat), 32'd6);

    // WB-only read makes WB the last grant
    wb_start(1'b0, 32'h3000_0020, 32'h0);
    run(30);
    chk("wbr8_data", wb_rd, 32'h0BAD_CAFE);

    // Tie with last grant WB: LA served first, WB waits
    base = log_q.size();
    la_start(1'b0, 8'd9, 32'h0);
    @(negedge clk);
    wb_start(1'b0, 32'h3000_0020, 32'h0);
    run(40);
    chk("tie2_first_addr", 32'(log_at(base).addr), 32'd9);
    chk("tie2_second_addr", 32'(log_at(base + 1).addr), 32'd8);
    chk("tie2_la_data", la_rd, 32'hA5A5_0009);
    chk("tie2_wb_data", wb_rd, 32'h0BAD_CAFE);
    chk("tie2_la_lat", 32'(la_lat), 32'd4);
    chk("tie2_wb_lat", 32'(wb_lat), 32'd7);

    // Address outside the window is ignored
    cnt_ack = 0; cnt_en = 0; cnt_busy = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0800; dat_i = 32'h5555_AAAA;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack) cnt_ack++;
      if (mem_en) cnt_en++;
      if (busy) cnt_busy++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("nomatch_ack", 32'(cnt_ack), 32'd0);
    chk("nomatch_mem_en", 32'(cnt_en), 32'd0);
    chk("nomatch_busy", 32'(cnt_busy), 32'd0);
    @(negedge clk);

    // cyc dropped mid-transaction: access completes, no ack
    wb_start(1'b0, 32'h3000_0010, 32'h0);
    @(negedge clk);
    chk("abort_mem_en", 32'(mem_en), 32'd1);
    cyc = 1'b0; stb = 1'b0; wb_act = 1'b0;
    cnt_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) cnt_ack++;
    end
    chk("abort_ack", 32'(cnt_ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // Reset asserted during WAIT
    wb_start(1'b0, 32'h3000_0010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wb_dat", dat_o, 32'd0);
    chk("mid_rst_la_rdata", la_rdata, 32'd0);
    cyc = 1'b0; stb = 1'b0; wb_act = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt_ack = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) cnt_ack++;
    end
    chk("post_rst_ack", 32'(cnt_ack), 32'd0);
    wb_start(1'b0, 32'h3000_0010, 32'h0);
    run(30);
    chk("post_rst_lat", 32'(wb_lat), 32'd3);
    chk("post_rst_data", wb_rd, 32'hDEAD_BEEF);

    // MEM_LAT=3 instance
    wb3_txn(1'b1, 32'h3000_0018, 32'hCAFE_F00D, lat3, rd3);
    chk("lat3_write_lat", 32'(lat3), 32'd2);
    wb3_txn(1'b0, 32'h3000_0018, 32'h0, lat3, rd3);
    chk("lat3_read_lat", 32'(lat3), 32'd5);
    chk("lat3_read_data", rd3, 32'hCAFE_F00D);
    chk("lat3_busy", 32'(busy3), 32'd0);
    chk("lat3_la_done", 32'(l3_done), 32'd0);
    chk("lat3_la_rdata", l3_rdata, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
